uart_rx_loader: RTL and testbench

Serial front end that feeds the GPIO register stage. It receives standard 8N1 UART frames on one input pin and presents each received byte as a single-cycle write strobe plus data word, wired directly to the GPIO register's write-enable and write-data. This replaces parallel pin loading of the duty/segment value with a one-pin serial link.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 36 +++
 rtl/uart_rx_loader.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive front end: the receiver state
// encoding, the default bit period and the smallest bit period the receiver
// accepts.
package uart_pkg;

    // 12 MHz clock / 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    // Below this the half-bit offset and the synchronizer delay leave no
    // usable window around the mid-bit sample point.
    localparam int MIN_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Generic two-flop synchronizer for bringing asynchronous pins into the clk
// domain. Both stages load RESET_VAL on reset so the synchronized output
// starts at the pin's idle level instead of producing a false edge.
//
// Ports:
//   clk - the single clock
//   rst - synchronous, active-high reset
//   d   - asynchronous input(s)
//   q   - synchronized output(s), two clk cycles behind d
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_loader.sv
// uart_rx_loader
// Receives 8N1 UART frames on a single pin and turns each good byte into a
// one-cycle write strobe plus data word, suitable for driving the GPIO
// register's write port directly (rxd comes from a ui_in pin). A bad stop bit
// produces a one-cycle frame_err instead, and the receiver then waits for the
// line to return high so a held-low line (break) cannot yield a bogus frame.
//
// Ports:
//   clk       - the single clock
//   rst       - synchronous, active-high reset (wins over ena)
//   ena       - block enable; low aborts any frame in progress
//   rxd       - raw asynchronous serial line, idle high
//   wdata     - last correctly received byte (held between frames)
//   we        - one-cycle strobe, wdata valid in that cycle
//   frame_err - one-cycle strobe on a bad stop bit
//   busy      - high whenever the receiver is not idle
module uart_rx_loader
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       rxd,
    output logic [7:0] wdata,
    output logic       we,
    output logic       frame_err,
    output logic       busy
);

    if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_clks_per_bit
        $error("uart_rx_loader: CLKS_PER_BIT must be at least %0d", MIN_CLKS_PER_BIT);
    end

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic rx_s;

    // The serial line idles high, so the synchronizer resets to 1.
    sync_2ff #(
        .WIDTH    (1),
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk(clk),
        .rst(rst),
        .d  (rxd),
        .q  (rx_s)
    );

    rx_state_e        state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       idx_q,       idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       wdata_q,     wdata_d;
    logic             we_q,        we_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        frame_err_d = 1'b0;

        if (!ena) begin
            // Abort: the partial byte is simply never committed to wdata.
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end

                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            idx_d   = '0;
                        end else begin
                            // Line went back high before mid-start: a glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = rx_s;
                        if (idx_q == 3'd7) begin
                            state_d = STOP;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            // Back to IDLE at the mid-stop sample so a start
                            // bit with no idle gap is still caught.
                            wdata_d = shift_q;
                            we_d    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign wdata     = wdata_q;
    assign we        = we_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_loader.sv
// tb_uart_rx_loader
// Directed bench for uart_rx_loader at CLKS_PER_BIT=16. rxd is driven on the
// falling edge; a falling-edge monitor counts strobes and busy cycles. With
// rxd dropped at a falling edge when the cycle counter reads s, the first
// synchronizer capture is rising edge s+1 (E0), so a strobe raised at
// E0+2+8+144 is first seen at the falling edge where the counter reads s+155.
module tb_uart_rx_loader;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] wdata;
    logic       we;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         cyc      = 0;
    int         we_cnt   = 0;
    int         we_cyc   = -1;
    logic [7:0] we_data  = 8'h00;
    int         fe_cnt   = 0;
    int         fe_cyc   = -1;
    int         both_cnt = 0;
    int         busy_cnt = 0;

    uart_rx_loader #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .rxd      (rxd),
        .wdata    (wdata),
        .we       (we),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we) begin
            we_cnt  = we_cnt + 1;
            we_cyc  = cyc;
            we_data = wdata;
        end
        if (frame_err) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
        if (we && frame_err) both_cnt = both_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives start, 8 data bits LSB first and the stop bit, CPB cycles each,
    // but stops after ncyc cycles. Called and returns on a falling edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int ncyc, output int start);
        start = cyc;
        for (int k = 0; k < ncyc && k < 10 * CPB; k++) begin
            int bitn;
            bitn = k / CPB;
            if (bitn == 0)      rxd = 1'b0;
            else if (bitn <= 8) rxd = b[3'(bitn - 1)];
            else                rxd = stop_bit;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int         s;
        int         w0;
        int         f0;
        int         c1;
        logic [7:0] d1;

        // Reset state
        rst = 1'b1;
        idle(3);
        check("rst_wdata", 32'(wdata), 32'h00);
        check("rst_we", 32'(we), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        idle(5);

        // Good frame 0xA5
        w0 = we_cnt;
        f0 = fe_cnt;
        send_frame(8'hA5, 1'b1, 10 * CPB, s);
        idle(10);
        check("a5_we_pulses", 32'(we_cnt - w0), 32'd1);
        check("a5_we_cycle", 32'(we_cyc), 32'(s + 155));
        check("a5_strobe_data", 32'(we_data), 32'hA5);
        check("a5_wdata_held", 32'(wdata), 32'hA5);
        check("a5_no_frame_err", 32'(fe_cnt - f0), 32'd0);

        // Two-cycle low glitch on an idle line
        w0 = we_cnt;
        f0 = fe_cnt;
        busy_cnt = 0;
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        idle(30);
        check("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
        check("glitch_no_we", 32'(we_cnt - w0), 32'd0);
        check("glitch_no_frame_err", 32'(fe_cnt - f0), 32'd0);
        check("glitch_idle", 32'(busy), 32'h0);

        // Bad stop bit, line held low, then 0x3C
        w0 = we_cnt;
        f0 = fe_cnt;
        send_frame(8'h55, 1'b0, 10 * CPB, s);
        idle(50);
        check("break_busy_mid", 32'(busy), 32'h1);
        idle(50);
        check("break_busy_end", 32'(busy), 32'h1);
        check("ferr_pulses", 32'(fe_cnt - f0), 32'd1);
        check("ferr_cycle", 32'(fe_cyc), 32'(s + 155));
        check("ferr_no_we", 32'(we_cnt - w0), 32'd0);
        check("ferr_wdata_kept", 32'(wdata), 32'hA5);
        rxd = 1'b1;
        idle(5);
        check("break_release_idle", 32'(busy), 32'h0);
        send_frame(8'h3C, 1'b1, 10 * CPB, s);
        idle(10);
        check("after_break_we", 32'(we_cnt - w0), 32'd1);
        check("after_break_wdata", 32'(wdata), 32'h3C);
        check("after_break_fe_total", 32'(fe_cnt - f0), 32'd1);

        // Back-to-back 0x00 then 0xFF, no idle gap
        w0 = we_cnt;
        send_frame(8'h00, 1'b1, 10 * CPB, s);
        c1 = we_cyc;
        d1 = we_data;
        send_frame(8'hFF, 1'b1, 10 * CPB, s);
        idle(10);
        check("b2b_pulses", 32'(we_cnt - w0), 32'd2);
        check("b2b_spacing", 32'(we_cyc - c1), 32'd160);
        check("b2b_first_data", 32'(d1), 32'h00);
        check("b2b_second_data", 32'(we_data), 32'hFF);

        // Reset mid bit 4 of 0x5A, then 0x81
        w0 = we_cnt;
        send_frame(8'h5A, 1'b1, 5 * CPB + 8, s);
        check("rst_mid_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        rxd = 1'b1;
        idle(1);
        check("rst_mid_wdata", 32'(wdata), 32'h00);
        check("rst_mid_we", 32'(we), 32'h0);
        check("rst_mid_frame_err", 32'(frame_err), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        idle(200);
        check("rst_mid_no_we", 32'(we_cnt - w0), 32'd0);
        send_frame(8'h81, 1'b1, 10 * CPB, s);
        idle(10);
        check("after_rst_we", 32'(we_cnt - w0), 32'd1);
        check("after_rst_wdata", 32'(wdata), 32'h81);

        // ena dropped for 3 cycles mid-frame, then 0x7E
        w0 = we_cnt;
        f0 = fe_cnt;
        send_frame(8'h7E, 1'b1, 60, s);
        check("ena_busy_before", 32'(busy), 32'h1);
        ena = 1'b0;
        rxd = 1'b1;
        idle(1);
        check("ena_low_busy", 32'(busy), 32'h0);
        idle(2);
        ena = 1'b1;
        idle(200);
        check("ena_no_we", 32'(we_cnt - w0), 32'd0);
        check("ena_no_frame_err", 32'(fe_cnt - f0), 32'd0);
        check("ena_wdata_held", 32'(wdata), 32'h81);
        send_frame(8'h7E, 1'b1, 10 * CPB, s);
        idle(10);
        check("after_ena_we", 32'(we_cnt - w0), 32'd1);
        check("after_ena_wdata", 32'(wdata), 32'h7E);

        check("we_fe_never_together", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
